sprite_fetcher: RTL
===================

// Module: sprite_fetcher
// PURPOSE
//  Responder for the sprite-fetch request produced by OAM evaluation: accepts sprite_fetch,
//  waits for OAM tile/attr to settle and the BG fetcher to reach a step boundary, reads the
//  two tile-row bytes from VRAM, applies X-flip and merges 8 pixels into the sprite pixel
//  FIFO, then signals sprite_fetch_done. Sits inside the PPU between sprites and the mixer.
// PARAMETERS
//  OAM_SETTLE  2  ce cycles sprite_fetch must be held before sprite_addr/sprite_attr are used
//  FIFO_DEPTH  8  sprite pixel slots (fixed by hardware; other values unsupported)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high reset
//  ce                in   1   PPU clock enable; all state advances only when ce=1
//  lcd_on            in   1   0 = force idle, clear FIFO
//  isGBC             in   1   CGB mode: bank select, CGB palette, OAM-order priority
//  line_start        in   1   one-ce pulse at mode-2 start: clear FIFO
//  sprite_fetch      in   1   request from sprites; drops the ce after done is seen
//  sprite_addr       in   11  tile row index {tile,row}; valid after OAM_SETTLE ce
//  sprite_attr       in   8   [7]prio [6]yflip(done upstream) [5]xflip [4]dmgpal [3]bank [2:0]cgbpal
//  sprite_index      in   4   line slot 0-9 (OAM order) of the requested sprite
//  bg_fetch_idle     in   1   BG fetcher at step boundary; VRAM free for sprite reads
//  sprite_fetch_done out  1   high from completion until sprite_fetch low
//  sprite_busy       out  1   state!=IDLE; stalls BG fetcher and pixel output
//  vram_rd           out  1   VRAM read strobe
//  vram_addr         out  13  {1'b0, sprite_addr, plane}
//  vram_bank         out  1   sprite_attr[3] & isGBC
//  vram_data         in   8   read data, valid the ce after vram_rd
//  spr_shift         in   1   mixer consumes slot 0
//  spr_pix_color     out  2   slot 0 colour (0 = transparent)
//  spr_pix_pal       out  3   slot 0 CGB palette
//  spr_pix_dmgpal    out  1   slot 0 DMG palette select
//  spr_pix_prio      out  1   slot 0 BG-over-OBJ flag
// BEHAVIOUR
//  Reset/lcd_on=0: state IDLE, all outputs 0, all FIFO slots colour 0, settle cnt 0.
//  FSM (per ce): IDLE -sprite_fetch-> SETTLE; SETTLE holds until cnt==OAM_SETTLE-1 and
//   bg_fetch_idle -> RD_LO (vram_rd=1, plane 0) -> RD_HI (latch lo=vram_data; vram_rd=1,
//   plane 1) -> MERGE (hi=vram_data; write FIFO) -> DONE (done=1) -> IDLE when sprite_fetch=0.
//  Latency, bg idle: fetch sampled at ce n -> done=1 at ce n+6; each bg-busy ce adds one.
//  Abort: sprite_fetch=0 in SETTLE/RD_LO/RD_HI/MERGE -> IDLE next ce, FIFO untouched, no done.
//  sprite_attr/sprite_index latched on SETTLE exit; later changes ignored.
//  Pixel p (0=leftmost) = {hi[7-p],lo[7-p]}; xflip uses bit p.
//  Merge slot p: write if slot colour==0, or isGBC and new index < stored index and new
//   colour!=0. DMG: earlier fetched opaque pixel always kept. Slot stores colour,pal,dmgpal,prio,index.
//  spr_shift: slots move down by 1, slot 7 becomes transparent. Shift in same ce as MERGE:
//   shift first, merge into post-shift slots (pixel p into slot p).
//  line_start clears FIFO, does not alter FSM; reset dominates line_start dominates shift.
// STRUCTURE
//  Shared package gb_ppu_pkg: FSM state encoding, attr bit indices, slot struct widths.
//  One sub-module: sprite_pixel_fifo (8-slot storage, shift, priority merge); FSM stays top.
// TESTING
//  1 DMG, attr=0x00, lo=0xF0 hi=0xCC, bg idle: done at ce n+6; slot colours 3,3,1,1,2,2,0,0.
//  2 Same bytes, attr=0x20: slot colours 0,0,2,2,1,1,3,3; vram_addr plane bit 0 then 1.
//  3 Overlap: fetch A colours all 1, then B all 2: DMG keeps 1; GBC with B index < A -> 2.
//  4 bg_fetch_idle low 3 ce during SETTLE: vram_rd first asserts 3 ce later, done at n+9.
//  5 sprite_fetch drops in RD_HI: IDLE next ce, done stays 0, FIFO unchanged.
//  6 reset or lcd_on=0 mid RD_LO: vram_rd=0, done=0, spr_pix_color=0 next ce; isGBC bank=attr[3].

Source files
------------

// File: rtl/gb_ppu_pkg.sv
// Shared PPU definitions: sprite-fetch FSM encoding, OAM attribute bit positions,
// sprite FIFO slot layout and the tile-row pixel extraction helper.
package gb_ppu_pkg;

  localparam int OAM_SETTLE = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = (OAM_SETTLE > 1) ? $clog2(OAM_SETTLE) : 1;

  localparam int ATTR_PRIO   = 7;
  localparam int ATTR_YFLIP  = 6;
  localparam int ATTR_XFLIP  = 5;
  localparam int ATTR_DMGPAL = 4;
  localparam int ATTR_BANK   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RD_LO  = 3'd2,
    ST_RD_HI  = 3'd3,
    ST_MERGE  = 3'd4,
    ST_DONE   = 3'd5
  } fetch_state_t;

  typedef struct packed {
    logic [1:0] color;
    logic [2:0] pal;
    logic       dmgpal;
    logic       prio;
    logic [3:0] index;
  } spr_slot_t;

  // Pixel p counts from the left; without X-flip the leftmost pixel is bit 7.
  function automatic logic [1:0] pixel_color(input logic [7:0] lo, input logic [7:0] hi,
                                             input logic xflip, input logic [2:0] p);
    logic [2:0] b;
    b = xflip ? p : (3'd7 - p);
    return {hi[b], lo[b]};
  endfunction

endpackage

// File: rtl/sprite_pixel_fifo.sv
// Eight-slot sprite pixel store: shift toward the mixer, then priority-merge a fetched
// tile row into the post-shift slots.
module sprite_pixel_fifo
  import gb_ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       clear,
  input  logic       shift,
  input  logic       merge,
  input  logic       isGBC,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic       xflip,
  input  logic [2:0] pal,
  input  logic       dmgpal,
  input  logic       prio,
  input  logic [3:0] index,
  output spr_slot_t  head
);

  spr_slot_t slots   [FIFO_DEPTH];
  spr_slot_t shifted [FIFO_DEPTH];
  spr_slot_t nxt     [FIFO_DEPTH];
  logic [1:0] new_color [FIFO_DEPTH];

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      shifted[i]   = slots[i];
      new_color[i] = pixel_color(lo, hi, xflip, 3'(i));
    end
    if (shift) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) shifted[i] = slots[i + 1];
      shifted[FIFO_DEPTH - 1] = '0;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      nxt[i] = shifted[i];
      // DMG keeps the earlier opaque pixel; CGB lets a lower OAM index win.
      if (merge && ((shifted[i].color == 2'd0) ||
                    (isGBC && (index < shifted[i].index) && (new_color[i] != 2'd0)))) begin
        nxt[i].color  = new_color[i];
        nxt[i].pal    = pal;
        nxt[i].dmgpal = dmgpal;
        nxt[i].prio   = prio;
        nxt[i].index  = index;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
    end else if (ce) begin
      if (clear) begin
        for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= '0;
      end else begin
        for (int i = 0; i < FIFO_DEPTH; i++) slots[i] <= nxt[i];
      end
    end
  end

  assign head = slots[0];

endmodule

// File: rtl/sprite_fetcher.sv
// Sprite tile-row fetcher: waits for OAM to settle and VRAM to be free, reads both
// bit-planes, merges eight pixels into the sprite FIFO and handshakes completion.
//
//  state  | meaning
//  IDLE   | no request; outputs low
//  SETTLE | waiting OAM_SETTLE ce for addr/attr, then for bg_fetch_idle
//  RD_LO  | reading plane 0
//  RD_HI  | latching plane 0, reading plane 1
//  MERGE  | plane 1 on vram_data; write FIFO
//  DONE   | sprite_fetch_done high until request drops
module sprite_fetcher
  import gb_ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        lcd_on,
  input  logic        isGBC,
  input  logic        line_start,
  input  logic        sprite_fetch,
  input  logic [10:0] sprite_addr,
  input  logic [7:0]  sprite_attr,
  input  logic [3:0]  sprite_index,
  input  logic        bg_fetch_idle,
  output logic        sprite_fetch_done,
  output logic        sprite_busy,
  output logic        vram_rd,
  output logic [12:0] vram_addr,
  output logic        vram_bank,
  input  logic [7:0]  vram_data,
  input  logic        spr_shift,
  output logic [1:0]  spr_pix_color,
  output logic [2:0]  spr_pix_pal,
  output logic        spr_pix_dmgpal,
  output logic        spr_pix_prio
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(OAM_SETTLE - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] settle_cnt;
  logic [10:0]      addr_q;
  logic             xflip_q;
  logic [2:0]       pal_q;
  logic             dmgpal_q;
  logic             prio_q;
  logic [3:0]       index_q;
  logic [7:0]       lo_q;
  logic             merge_en;
  logic             yflip_unused;
  spr_slot_t        head;

  // Y-flip is already folded into sprite_addr by OAM evaluation.
  assign yflip_unused = sprite_attr[ATTR_YFLIP];

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      settle_cnt        <= '0;
      addr_q            <= '0;
      xflip_q           <= 1'b0;
      pal_q             <= '0;
      dmgpal_q          <= 1'b0;
      prio_q            <= 1'b0;
      index_q           <= '0;
      lo_q              <= '0;
      sprite_busy       <= 1'b0;
      sprite_fetch_done <= 1'b0;
      vram_rd           <= 1'b0;
      vram_addr         <= '0;
      vram_bank         <= 1'b0;
    end else if (ce) begin
      if (!lcd_on || !sprite_fetch) begin
        state             <= ST_IDLE;
        settle_cnt        <= '0;
        sprite_busy       <= 1'b0;
        sprite_fetch_done <= 1'b0;
        vram_rd           <= 1'b0;
        vram_addr         <= '0;
        vram_bank         <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state       <= ST_SETTLE;
            settle_cnt  <= '0;
            sprite_busy <= 1'b1;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              if (bg_fetch_idle) begin
                addr_q    <= sprite_addr;
                xflip_q   <= sprite_attr[ATTR_XFLIP];
                pal_q     <= sprite_attr[2:0];
                dmgpal_q  <= sprite_attr[ATTR_DMGPAL];
                prio_q    <= sprite_attr[ATTR_PRIO];
                index_q   <= sprite_index;
                state     <= ST_RD_LO;
                vram_rd   <= 1'b1;
                vram_addr <= {1'b0, sprite_addr, 1'b0};
                vram_bank <= sprite_attr[ATTR_BANK] & isGBC;
              end
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_RD_LO: begin
            state     <= ST_RD_HI;
            vram_addr <= {1'b0, addr_q, 1'b1};
          end
          ST_RD_HI: begin
            lo_q      <= vram_data;
            state     <= ST_MERGE;
            vram_rd   <= 1'b0;
            vram_addr <= '0;
            vram_bank <= 1'b0;
          end
          ST_MERGE: begin
            state             <= ST_DONE;
            sprite_fetch_done <= 1'b1;
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state       <= ST_IDLE;
            sprite_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  // An abort on the MERGE ce must leave the FIFO untouched.
  assign merge_en = lcd_on && sprite_fetch && (state == ST_MERGE);

  sprite_pixel_fifo u_fifo (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .clear  (!lcd_on || line_start),
    .shift  (spr_shift),
    .merge  (merge_en),
    .isGBC  (isGBC),
    .lo     (lo_q),
    .hi     (vram_data),
    .xflip  (xflip_q),
    .pal    (pal_q),
    .dmgpal (dmgpal_q),
    .prio   (prio_q),
    .index  (index_q),
    .head   (head)
  );

  assign spr_pix_color  = head.color;
  assign spr_pix_pal    = head.pal;
  assign spr_pix_dmgpal = head.dmgpal;
  assign spr_pix_prio   = head.prio;

endmodule
